conv_row_adr_sequencer: RTL and testbench

CONV_ROW_ADR_SEQUENCER -- requirements
Module: conv_row_adr_sequencer

---
 rtl/conv_adr_pkg.sv | 38 +++
 rtl/conv_row_ring_map.sv | 34 +++
 rtl/conv_row_adr_sequencer.sv | 173 +++++++++++++++++
 tb/tb_conv_row_adr_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_adr_pkg.sv
// Shared types for the convolution row address sequencer: FSM states, the
// output beat record, the padding sentinel and the address shift helper.
package conv_adr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } seq_state_e;

  // Beat fields are sized for the widest supported configuration; the top
  // slices them down to its own parameter widths.
  localparam int unsigned BeatLaneW = 8;
  localparam int unsigned BeatBufW  = 3;
  localparam int unsigned BeatAdrW  = 32;

  typedef struct packed {
    logic [BeatLaneW-1:0] lane;
    logic [BeatAdrW-1:0]  row_idx;
    logic [BeatBufW-1:0]  buf_idx;
    logic [BeatAdrW-1:0]  buf_adr;
    logic                 pad;
  } beat_t;

  localparam logic [BeatAdrW-1:0] AdrAllOnes = '1;

  // Words per buffer row expressed as a shift; rows narrower than one word clamp to 0.
  function automatic logic [5:0] adr_shift(logic [3:0] nif_2pow, logic [3:0] ix_2pow,
                                           int unsigned pix_2pow);
    logic [5:0] sum;
    sum = 6'(nif_2pow) + 6'(ix_2pow);
    if (int'(sum) > int'(pix_2pow)) begin
      return sum - 6'(pix_2pow);
    end
    return 6'd0;
  endfunction

endpackage

// File: rtl/conv_row_ring_map.sv
// Maps a row index onto the row-buffer ring: slot = row mod BUF_NUM,
// row within slot = row / BUF_NUM, via unrolled compare-subtract by a constant.
module conv_row_ring_map #(
  parameter int unsigned BUF_NUM = 3,
  parameter int unsigned ADR_W   = 16,
  localparam int unsigned BufW   = $clog2(BUF_NUM)
) (
  input  logic [ADR_W-1:0] row_i,
  output logic [BufW-1:0]  buf_idx_o,
  output logic [ADR_W-1:0] buf_row_o
);

  // One extra bit holds the shifted-in remainder before the compare.
  localparam int unsigned RemW = BufW + 1;

  logic [RemW-1:0]  rem;
  logic [ADR_W-1:0] quo;

  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = ADR_W - 1; i >= 0; i--) begin
      rem = {rem[RemW-2:0], row_i[i]};
      if (rem >= RemW'(BUF_NUM)) begin
        rem    = rem - RemW'(BUF_NUM);
        quo[i] = 1'b1;
      end
    end
  end

  assign buf_idx_o = rem[BufW-1:0];
  assign buf_row_o = quo;

endmodule

// File: rtl/conv_row_adr_sequencer.sv
// Walks ky x input-chunk x lane for one job and emits row-buffer addresses as
// valid/ready beats. Define CONV_ROW_ADR_PAD_SKIP_EN to drop padding beats.
module conv_row_adr_sequencer
  import conv_adr_pkg::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned BUF_NUM  = 3,
  parameter int unsigned ADR_W    = 16,
  parameter int unsigned PIX_2POW = 5,
  localparam int unsigned LaneW   = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int unsigned BufW    = $clog2(BUF_NUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       cfg_s,
  input  logic [3:0]       cfg_p,
  input  logic [ADR_W-1:0] cfg_iy,
  input  logic [ADR_W-1:0] cfg_iy_start,
  input  logic [3:0]       cfg_ky,
  input  logic [ADR_W-1:0] cfg_nif_chunks,
  input  logic [3:0]       cfg_nif_in_2pow,
  input  logic [3:0]       cfg_ix_in_2pow,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LaneW-1:0] out_lane,
  output logic [ADR_W-1:0] out_row_idx,
  output logic [BufW-1:0]  out_buf_idx,
  output logic [ADR_W-1:0] out_buf_adr,
  output logic             out_pad,
  output logic             done
);

  seq_state_e       state_q;
  logic [2:0]       cfg_s_q;
  logic [3:0]       cfg_p_q, cfg_ky_q, cfg_nif_q, cfg_ix_q;
  logic [ADR_W-1:0] cfg_iy_q, cfg_iy_start_q, cfg_chunks_q;
  logic [LaneW-1:0] lane_q;
  logic [ADR_W-1:0] if_q;
  logic [3:0]       ky_q;
  beat_t            beat_q, beat_d;
  logic             out_valid_q, done_q;

  logic [ADR_W-1:0] ext, row, map_row, adr_word;
  logic [BufW-1:0]  map_idx;
  logic [5:0]       sh;
  logic             pad, emit, adv, lane_last, if_last, ky_last;

  conv_row_ring_map #(
    .BUF_NUM(BUF_NUM),
    .ADR_W  (ADR_W)
  ) u_ring_map (
    .row_i    (row),
    .buf_idx_o(map_idx),
    .buf_row_o(map_row)
  );

  always_comb begin
    ext = ADR_W'(ky_q) + cfg_iy_start_q + ADR_W'(lane_q) * ADR_W'(cfg_s_q);
    // Upper bound compared one bit wider so p + iy cannot wrap.
    pad = (ext < ADR_W'(cfg_p_q)) ||
          ({1'b0, ext} >= ({1'b0, ADR_W'(cfg_p_q)} + {1'b0, cfg_iy_q}));
    row = ext - ADR_W'(cfg_p_q);
    sh  = adr_shift(cfg_nif_q, cfg_ix_q, PIX_2POW);
    adr_word = map_row << sh;
    adr_word = adr_word + if_q;

    beat_d      = '0;
    beat_d.lane = BeatLaneW'(lane_q);
    if (pad) begin
      beat_d.row_idx = AdrAllOnes;
      beat_d.buf_adr = AdrAllOnes;
      beat_d.pad     = 1'b1;
    end else begin
      beat_d.row_idx = BeatAdrW'(row);
      beat_d.buf_idx = BeatBufW'(map_idx);
      beat_d.buf_adr = BeatAdrW'(adr_word);
    end

`ifdef CONV_ROW_ADR_PAD_SKIP_EN
    emit = !pad;
`else
    emit = 1'b1;
`endif

    adv       = !out_valid_q || out_ready;
    lane_last = (lane_q == LaneW'(LANES - 1));
    if_last   = (if_q == cfg_chunks_q - ADR_W'(1));
    ky_last   = (ky_q == cfg_ky_q - 4'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cfg_s_q        <= '0;
      cfg_p_q        <= '0;
      cfg_iy_q       <= '0;
      cfg_iy_start_q <= '0;
      cfg_ky_q       <= '0;
      cfg_chunks_q   <= '0;
      cfg_nif_q      <= '0;
      cfg_ix_q       <= '0;
      lane_q         <= '0;
      if_q           <= '0;
      ky_q           <= '0;
      beat_q         <= '0;
      out_valid_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cfg_s_q        <= cfg_s;
            cfg_p_q        <= cfg_p;
            cfg_iy_q       <= cfg_iy;
            cfg_iy_start_q <= cfg_iy_start;
            cfg_ky_q       <= cfg_ky;
            cfg_chunks_q   <= cfg_nif_chunks;
            cfg_nif_q      <= cfg_nif_in_2pow;
            cfg_ix_q       <= cfg_ix_in_2pow;
            lane_q         <= '0;
            if_q           <= '0;
            ky_q           <= '0;
            state_q        <= StRun;
          end
        end
        StRun: begin
          if (adv) begin
            beat_q      <= beat_d;
            out_valid_q <= emit;
            if (!lane_last) begin
              lane_q <= lane_q + LaneW'(1);
            end else begin
              lane_q <= '0;
              if (!if_last) begin
                if_q <= if_q + ADR_W'(1);
              end else begin
                if_q <= '0;
                ky_q <= ky_q + 4'd1;
                if (ky_last) begin
                  state_q <= StDrain;
                end
              end
            end
          end
        end
        StDrain: begin
          if (!out_valid_q || out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_beat_bits;
  assign unused_beat_bits = ^beat_q;

  assign busy        = (state_q != StIdle);
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign out_lane    = beat_q.lane[LaneW-1:0];
  assign out_row_idx = beat_q.row_idx[ADR_W-1:0];
  assign out_buf_idx = beat_q.buf_idx[BufW-1:0];
  assign out_buf_adr = beat_q.buf_adr[ADR_W-1:0];
  assign out_pad     = beat_q.pad;

endmodule

// File: tb/tb_conv_row_adr_sequencer.sv
// Bench for conv_row_adr_sequencer: a queue model of the beat sequence built
// from the addressing rules, checked on every accepted beat, plus literal checks.
module tb_conv_row_adr_sequencer;

  localparam int LANES = 2, BUF_NUM = 3, ADR_W = 16, PIX_2POW = 5;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  cfg_s = '0;
  logic [3:0]  cfg_p = '0, cfg_ky = '0, cfg_nif_in_2pow = '0, cfg_ix_in_2pow = '0;
  logic [15:0] cfg_iy = '0, cfg_iy_start = '0, cfg_nif_chunks = '0;
  logic        busy, out_valid, out_pad, done;
  logic        out_ready = 1'b1;
  logic [0:0]  out_lane;
  logic [15:0] out_row_idx, out_buf_adr;
  logic [1:0]  out_buf_idx;

  typedef struct packed {
    logic [0:0]  lane;
    logic [15:0] row;
    logic [1:0]  idx;
    logic [15:0] adr;
    logic        pad;
  } tb_beat_t;

  tb_beat_t exp_q[$], got_q[$], ref_q[$];
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, done_cnt = 0, last_acc = 0, done_base = 0;
  bit rand_mode = 1'b0, prev_stall = 1'b0;
  tb_beat_t prev_beat, cur, e;

  conv_row_adr_sequencer #(
    .LANES(LANES), .BUF_NUM(BUF_NUM), .ADR_W(ADR_W), .PIX_2POW(PIX_2POW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_s(cfg_s), .cfg_p(cfg_p), .cfg_iy(cfg_iy),
    .cfg_iy_start(cfg_iy_start), .cfg_ky(cfg_ky), .cfg_nif_chunks(cfg_nif_chunks),
    .cfg_nif_in_2pow(cfg_nif_in_2pow), .cfg_ix_in_2pow(cfg_ix_in_2pow), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_row_idx(out_row_idx), .out_buf_idx(out_buf_idx), .out_buf_adr(out_buf_adr),
    .out_pad(out_pad), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic tb_beat_t mk(int l, int r, int i, int a, bit p);
    tb_beat_t b;
    b.lane = 1'(l); b.row = 16'(r); b.idx = 2'(i); b.adr = 16'(a); b.pad = p;
    return b;
  endfunction

  // Expected beats straight from the addressing rules, using / and % freely.
  function automatic void build(int s, int p, int iy, int iys, int ky, int ch, int nif, int ix);
    int sh, ext, row;
    logic [31:0] a;
    exp_q.delete();
    sh = nif + ix - PIX_2POW;
    if (sh < 0) sh = 0;
    for (int k = 0; k < ky; k++)
      for (int f = 0; f < ch; f++)
        for (int l = 0; l < LANES; l++) begin
          ext = (k + iys + l * s) % 65536;
          if (ext < p || ext >= p + iy) begin
`ifndef CONV_ROW_ADR_PAD_SKIP_EN
            exp_q.push_back(mk(l, 16'hffff, 0, 16'hffff, 1'b1));
`endif
          end else begin
            row = ext - p;
            a = (32'(row / BUF_NUM) << sh) + 32'(f);
            exp_q.push_back(mk(l, row, row % BUF_NUM, int'(a[15:0]), 1'b0));
          end
        end
  endfunction

  always @(negedge clk) begin
    cur = {out_lane, out_row_idx, out_buf_idx, out_buf_adr, out_pad};
    if (reset) begin
      exp_q.delete();
      acc_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (!busy) chk("idle_valid", {63'd0, out_valid}, 64'd0);
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_hold", 64'(cur), 64'(prev_beat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(cur), 64'hdead);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", acc_cnt), 64'(cur), 64'(e));
        end
        got_q.push_back(cur);
        acc_cnt++;
        last_acc = cyc;
      end
      if (done) begin
        chk("done_gap", 64'(cyc - last_acc), 64'd1);
        chk("done_valid", {63'd0, out_valid}, 64'd0);
        chk("done_left", 64'(exp_q.size()), 64'd0);
        done_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur;
    end
  end

  task automatic launch(input int s, p, iy, iys, ky, ch, nif, ix);
    @(posedge clk); #2;
    cfg_s = 3'(s); cfg_p = 4'(p); cfg_iy = 16'(iy); cfg_iy_start = 16'(iys);
    cfg_ky = 4'(ky); cfg_nif_chunks = 16'(ch); cfg_nif_in_2pow = 4'(nif);
    cfg_ix_in_2pow = 4'(ix);
    build(s, p, iy, iys, ky, ch, nif, ix);
    got_q.delete();
    done_base = done_cnt;
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(posedge clk); #2;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      seen = (done_cnt > done_base);
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic wait_acc(input int n, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(posedge clk); #2;
      seen = (acc_cnt >= n);
    end
    if (!seen) chk("acc_timeout", 64'(acc_cnt), 64'(n));
  endtask

  task automatic chk_zero_outs(input string name);
    chk(name, {busy, out_valid, done, out_pad, out_lane, out_row_idx, out_buf_idx, out_buf_adr},
        64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_zero_outs("reset_outs");

    // Stride 2, no padding: latency and ring mapping.
    launch(2, 0, 8, 2, 1, 1, 1, 5);
    @(negedge clk);
    chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    chk("lat_cycle1_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    wait_done(50);
    chk("s2_count", 64'(got_q.size()), 64'd2);
    chk("s2_beat0", 64'(got_q[0]), 64'(mk(0, 2, 2, 0, 1'b0)));
    chk("s2_beat1", 64'(got_q[1]), 64'(mk(1, 4, 1, 2, 1'b0)));

    // Padded job, full throughput, with an ignored start mid-job.
    launch(1, 1, 4, 0, 3, 2, 1, 5);
    wait_acc(3, 50);
    cfg_ky = 4'd1; cfg_s = 3'd4; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(100);
`ifdef CONV_ROW_ADR_PAD_SKIP_EN
    chk("p1_count", 64'(got_q.size()), 64'd10);
    chk("p1_beat0", 64'(got_q[0]), 64'(mk(1, 0, 0, 0, 1'b0)));
    chk("p1_beat1", 64'(got_q[1]), 64'(mk(1, 0, 0, 1, 1'b0)));
    chk("p1_beat9", 64'(got_q[9]), 64'(mk(1, 2, 2, 1, 1'b0)));
    foreach (got_q[i]) chk($sformatf("p1_nopad%0d", i), {63'd0, got_q[i].pad}, 64'd0);
`else
    chk("p1_count", 64'(got_q.size()), 64'd12);
    chk("p1_beat0_pad", {63'd0, got_q[0].pad}, 64'd1);
    chk("p1_beat1", 64'(got_q[1]), 64'(mk(1, 0, 0, 0, 1'b0)));
    chk("p1_beat3", 64'(got_q[3]), 64'(mk(1, 0, 0, 1, 1'b0)));
    chk("p1_beat11", 64'(got_q[11]), 64'(mk(1, 2, 2, 1, 1'b0)));
`endif
    ref_q = got_q;
    repeat (5) @(posedge clk);
    chk("no_second_job", 64'(done_cnt - done_base), 64'd1);

    // Same job under random back-pressure.
    rand_mode = 1'b1;
    launch(1, 1, 4, 0, 3, 2, 1, 5);
    wait_done(400);
    rand_mode = 1'b0;
    chk("rand_count", 64'(got_q.size()), 64'(ref_q.size()));
    foreach (ref_q[i]) chk($sformatf("rand_seq%0d", i), 64'(got_q[i]), 64'(ref_q[i]));

    // Reset mid-job, then restart on the first cycle after release.
    launch(1, 1, 4, 0, 3, 2, 1, 5);
    wait_acc(5, 50);
    reset = 1'b1;
    #1;
    chk_zero_outs("midreset_outs");
    launch(1, 1, 4, 0, 3, 2, 1, 5);
    wait_done(100);
    chk("restart_count", 64'(got_q.size()), 64'(ref_q.size()));
    foreach (ref_q[i]) chk($sformatf("restart_seq%0d", i), 64'(got_q[i]), 64'(ref_q[i]));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
